// File: rtl/butterfly_r2_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_r2_pipe
//   Radix-2 DIT butterfly with a three-stage pipeline:
//     X = A + B*W,  Y = A - B*W,  W = W8^k supplied by an external twiddle ROM.
//   S1 registers the operands and twiddle index (the index drives the ROM),
//   S2 registers the four B x W partial products, and S3 registers the rounded,
//   optionally scaled and saturated results.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is the pipeline advance)
//   a_re,a_im,b_re,b_im   12-bit signed operands A and B
//   tw_idx                twiddle index k, accepted with the operands
//   tw_index              registered index driven to the twiddle ROM
//   tw_re, tw_im          12-bit signed Q7 twiddle returned by the ROM
//   x_re,x_im,y_re,y_im   12-bit signed results
//   out_valid / out_ready result handshake
//
// Parameter
//   SCALE                 0: no scaling, 1: arithmetic shift right by 1
// -----------------------------------------------------------------------------
module butterfly_r2_pipe #(
  parameter int SCALE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] a_re,
  input  logic [11:0] a_im,
  input  logic [11:0] b_re,
  input  logic [11:0] b_im,
  input  logic [2:0]  tw_idx,
  output logic [2:0]  tw_index,
  input  logic [11:0] tw_re,
  input  logic [11:0] tw_im,
  output logic [11:0] x_re,
  output logic [11:0] x_im,
  output logic [11:0] y_re,
  output logic [11:0] y_im,
  output logic        out_valid,
  input  logic        out_ready
);

  // Global advance: the whole pipe moves when the output slot is free or
  // being consumed, so a stall freezes every stage at once.
  logic en;

  // Stage valid bits and twiddle index
  logic       v1_q, v1_d;
  logic       v2_q, v2_d;
  logic       v3_q, v3_d;
  logic [2:0] idx1_q, idx1_d;

  // S1 operands
  logic signed [11:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
  logic signed [11:0] b1_re_q, b1_re_d, b1_im_q, b1_im_d;

  // S2: A carried along, plus the four partial products
  logic signed [11:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
  logic signed [23:0] p_rr_q, p_rr_d;  // b_re * tw_re
  logic signed [23:0] p_ii_q, p_ii_d;  // b_im * tw_im
  logic signed [23:0] p_ri_q, p_ri_d;  // b_re * tw_im
  logic signed [23:0] p_ir_q, p_ir_d;  // b_im * tw_re

  // S3 results
  logic [11:0] x_re_q, x_re_d, x_im_q, x_im_d;
  logic [11:0] y_re_q, y_re_d, y_im_q, y_im_d;

  // S3 combinational arithmetic
  logic signed [24:0] t_re_full, t_im_full;
  logic signed [17:0] t_re, t_im;
  logic signed [18:0] sx_re, sx_im, sy_re, sy_im;

  function automatic logic signed [18:0] scale19(input logic signed [18:0] v);
    return (SCALE == 1) ? (v >>> 1) : v;
  endfunction

  function automatic logic [11:0] sat12(input logic signed [18:0] v);
    if (v > 19'sd2047)       return 12'h7ff;
    else if (v < -19'sd2048) return 12'h800;
    else                     return v[11:0];
  endfunction

  always_comb begin
    en = !v3_q || out_ready;

    // NOTE: every _d defaults to its _q (hold), so no path through this block
    // leaves a variable unassigned and no latch can be inferred.
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    idx1_d  = idx1_q;
    a1_re_d = a1_re_q;
    a1_im_d = a1_im_q;
    b1_re_d = b1_re_q;
    b1_im_d = b1_im_q;
    a2_re_d = a2_re_q;
    a2_im_d = a2_im_q;
    p_rr_d  = p_rr_q;
    p_ii_d  = p_ii_q;
    p_ri_d  = p_ri_q;
    p_ir_d  = p_ir_q;
    x_re_d  = x_re_q;
    x_im_d  = x_im_q;
    y_re_d  = y_re_q;
    y_im_d  = y_im_q;

    // Complex product B*W at 25 bits, then round half up back to Q0 (18 bits)
    t_re_full = 25'(p_rr_q) - 25'(p_ii_q);
    t_im_full = 25'(p_ri_q) + 25'(p_ir_q);
    t_re      = 18'((t_re_full + 25'sd64) >>> 7);
    t_im      = 18'((t_im_full + 25'sd64) >>> 7);

    sx_re = scale19(19'(a2_re_q) + 19'(t_re));
    sx_im = scale19(19'(a2_im_q) + 19'(t_im));
    sy_re = scale19(19'(a2_re_q) - 19'(t_re));
    sy_im = scale19(19'(a2_im_q) - 19'(t_im));

    if (en) begin
      // S1: a bubble (in_valid = 0) is captured as an invalid slot
      v1_d    = in_valid;
      idx1_d  = tw_idx;
      a1_re_d = a_re;
      a1_im_d = a_im;
      b1_re_d = b_re;
      b1_im_d = b_im;
      // S2: tw_re/tw_im are the ROM response to idx1_q of this same word
      v2_d    = v1_q;
      a2_re_d = a1_re_q;
      a2_im_d = a1_im_q;
      p_rr_d  = 24'(b1_re_q) * 24'($signed(tw_re));
      p_ii_d  = 24'(b1_im_q) * 24'($signed(tw_im));
      p_ri_d  = 24'(b1_re_q) * 24'($signed(tw_im));
      p_ir_d  = 24'(b1_im_q) * 24'($signed(tw_re));
      // S3
      v3_d    = v2_q;
      x_re_d  = sat12(sx_re);
      x_im_d  = sat12(sx_im);
      y_re_d  = sat12(sy_re);
      y_im_d  = sat12(sy_im);
    end
  end

  // Control and visible outputs: cleared by reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      idx1_q <= 3'd0;
      x_re_q <= 12'd0;
      x_im_q <= 12'd0;
      y_re_q <= 12'd0;
      y_im_q <= 12'd0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      idx1_q <= idx1_d;
      x_re_q <= x_re_d;
      x_im_q <= x_im_d;
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
    end
  end

  // NOTE: internal datapath registers carry no reset; their contents are
  // qualified by the stage valid bits, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    a1_re_q <= a1_re_d;
    a1_im_q <= a1_im_d;
    b1_re_q <= b1_re_d;
    b1_im_q <= b1_im_d;
    a2_re_q <= a2_re_d;
    a2_im_q <= a2_im_d;
    p_rr_q  <= p_rr_d;
    p_ii_q  <= p_ii_d;
    p_ri_q  <= p_ri_d;
    p_ir_q  <= p_ir_d;
  end

  assign in_ready  = en;
  assign tw_index  = idx1_q;
  assign out_valid = v3_q;
  assign x_re      = x_re_q;
  assign x_im      = x_im_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;

endmodule
